// File: rtl/alu_muldiv_iter_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The unit connects through the slave modport; the issuing stage uses master.
interface alu_muldiv_iter_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned TagWidth  = 5
);
    logic                 flush_i;
    logic                 valid_i;
    logic                 ready_o;
    logic [2:0]           op_i;
    logic [DataWidth-1:0] srcA_i;
    logic [DataWidth-1:0] srcB_i;
    logic [TagWidth-1:0]  tag_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [DataWidth-1:0] result_o;
    logic [TagWidth-1:0]  tag_o;
    logic                 zero_o;
    logic                 negative_o;
    logic                 busy_o;

    modport slave (
        input  flush_i, valid_i, op_i, srcA_i, srcB_i, tag_i, ready_i,
        output ready_o, valid_o, result_o, tag_o, zero_o, negative_o, busy_o
    );

    modport master (
        output flush_i, valid_i, op_i, srcA_i, srcB_i, tag_i, ready_i,
        input  ready_o, valid_o, result_o, tag_o, zero_o, negative_o, busy_o
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide on magnitudes.
// Define MULDIV_RADIX4_EN to retire two multiplier bits per cycle (divide stays radix-2).
module alu_muldiv_iter #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned TagWidth  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    alu_muldiv_iter_if.slave  bus
);
    localparam int unsigned CntW = $clog2(DataWidth);
    localparam logic [DataWidth-1:0] MinNeg = {1'b1, {(DataWidth-1){1'b0}}};
`ifdef MULDIV_RADIX4_EN
    localparam int unsigned MulExt = 2;
`else
    localparam int unsigned MulExt = 1;
`endif

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t                 r_state, w_next;
    logic [2:0]             r_op;
    logic [TagWidth-1:0]    r_tag;
    logic [TagWidth-1:0]    r_tag_o;
    logic [2*DataWidth-1:0] r_acc;
    logic [DataWidth-1:0]   r_mcand;
    logic                   r_neg;
    logic [CntW-1:0]        r_cnt;
    logic [DataWidth-1:0]   r_result;
    logic                   r_valid;
`ifdef MULDIV_RADIX4_EN
    logic [DataWidth+1:0]   r_mcand3;
    logic [DataWidth+1:0]   w_addend;
`endif

    logic                   w_accept;
    logic                   w_a_signed, w_b_signed;
    logic                   w_sign_a, w_sign_b;
    logic [DataWidth-1:0]   w_mag_a, w_mag_b;
    logic                   w_div_zero, w_div_ovf, w_special;
    logic [DataWidth-1:0]   w_special_result;
    logic                   w_last;
    logic [DataWidth+MulExt-1:0] w_mul_sum;
    logic [DataWidth:0]     w_div_diff;
    logic [2*DataWidth-1:0] w_acc_step;
    logic [2*DataWidth-1:0] w_prod;
    logic [DataWidth-1:0]   w_div_val, w_div_res, w_fix_result;

    assign w_accept = bus.valid_i && (r_state == S_IDLE) && !bus.flush_i;

    assign w_a_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b010) || (bus.op_i[2] && !bus.op_i[0]);
    assign w_b_signed = (bus.op_i == 3'b001) || (bus.op_i[2] && !bus.op_i[0]);
    assign w_sign_a   = w_a_signed && bus.srcA_i[DataWidth-1];
    assign w_sign_b   = w_b_signed && bus.srcB_i[DataWidth-1];
    assign w_mag_a    = w_sign_a ? -bus.srcA_i : bus.srcA_i;
    assign w_mag_b    = w_sign_b ? -bus.srcB_i : bus.srcB_i;

    assign w_div_zero = bus.op_i[2] && (bus.srcB_i == '0);
    assign w_div_ovf  = bus.op_i[2] && !bus.op_i[0] && (bus.srcA_i == MinNeg) && (bus.srcB_i == '1);
    assign w_special  = w_div_zero || w_div_ovf;

    always_comb begin
        w_special_result = '0;
        if (w_div_zero)
            w_special_result = bus.op_i[1] ? bus.srcA_i : '1;
        else if (w_div_ovf)
            w_special_result = bus.op_i[1] ? '0 : MinNeg;
    end

`ifdef MULDIV_RADIX4_EN
    assign w_last = (r_cnt == (r_op[2] ? CntW'(DataWidth-1) : CntW'(DataWidth/2-1)));
`else
    assign w_last = (r_cnt == CntW'(DataWidth-1));
`endif

    // Multiply keeps the multiplier in the low half and shifts right; divide shifts the
    // dividend left through the high half, which ends up holding the remainder.
    always_comb begin
        w_acc_step = r_acc;
        w_mul_sum  = '0;
        w_div_diff = '0;
`ifdef MULDIV_RADIX4_EN
        w_addend   = '0;
`endif
        if (!r_op[2]) begin
`ifdef MULDIV_RADIX4_EN
            case (r_acc[1:0])
                2'b01:   w_addend = {2'b00, r_mcand};
                2'b10:   w_addend = {1'b0, r_mcand, 1'b0};
                2'b11:   w_addend = r_mcand3;
                default: w_addend = '0;
            endcase
            w_mul_sum  = {2'b00, r_acc[2*DataWidth-1:DataWidth]} + w_addend;
            w_acc_step = {w_mul_sum, r_acc[DataWidth-1:2]};
`else
            w_mul_sum  = {1'b0, r_acc[2*DataWidth-1:DataWidth]} + {1'b0, (r_acc[0] ? r_mcand : '0)};
            w_acc_step = {w_mul_sum, r_acc[DataWidth-1:1]};
`endif
        end else begin
            w_div_diff = r_acc[2*DataWidth-1:DataWidth-1] - {1'b0, r_mcand};
            if (!w_div_diff[DataWidth])
                w_acc_step = {w_div_diff[DataWidth-1:0], r_acc[DataWidth-2:0], 1'b1};
            else
                w_acc_step = {r_acc[2*DataWidth-2:0], 1'b0};
        end
    end

    assign w_prod       = r_neg ? -r_acc : r_acc;
    assign w_div_val    = r_op[1] ? r_acc[2*DataWidth-1:DataWidth] : r_acc[DataWidth-1:0];
    assign w_div_res    = r_neg ? -w_div_val : w_div_val;
    assign w_fix_result = r_op[2] ? w_div_res
                        : ((r_op[1:0] == 2'b00) ? w_prod[DataWidth-1:0] : w_prod[2*DataWidth-1:DataWidth]);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.flush_i) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) w_next = w_special ? S_DONE : S_CALC;
                S_CALC:  if (w_last) w_next = S_FIX;
                S_FIX:   w_next = S_DONE;
                S_DONE:  if (bus.ready_i) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_op     <= '0;
            r_tag    <= '0;
            r_tag_o  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
`ifdef MULDIV_RADIX4_EN
            r_mcand3 <= '0;
`endif
        end else if (bus.flush_i) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op    <= bus.op_i;
                    r_tag   <= bus.tag_i;
                    r_cnt   <= '0;
                    r_neg   <= (bus.op_i[2] && bus.op_i[1]) ? w_sign_a : (w_sign_a ^ w_sign_b);
                    r_acc   <= {{DataWidth{1'b0}}, (bus.op_i[2] ? w_mag_a : w_mag_b)};
                    r_mcand <= bus.op_i[2] ? w_mag_b : w_mag_a;
`ifdef MULDIV_RADIX4_EN
                    r_mcand3 <= {2'b00, w_mag_a} + {1'b0, w_mag_a, 1'b0};
`endif
                    if (w_special) begin
                        r_result <= w_special_result;
                        r_tag_o  <= bus.tag_i;
                        r_valid  <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_step;
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_result <= w_fix_result;
                    r_tag_o  <= r_tag;
                    r_valid  <= 1'b1;
                end
                S_DONE: if (bus.ready_i) r_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.ready_o    = (r_state == S_IDLE);
    assign bus.busy_o     = (r_state != S_IDLE);
    assign bus.valid_o    = r_valid;
    assign bus.result_o   = r_result;
    assign bus.tag_o      = r_tag_o;
    assign bus.zero_o     = r_valid && (r_result == '0);
    assign bus.negative_o = r_result[DataWidth-1];
endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Scoreboard bench for alu_muldiv_iter: directed RV32M cases, random ops, hold, flush and reset.
module tb_alu_muldiv_iter;
    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   tag;
        int unsigned  acc_cyc;
        int unsigned  lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    exp_t        sb[$];
    exp_t        e;
    logic        prev_valid = 1'b0;

    alu_muldiv_iter_if #(.DataWidth(W), .TagWidth(5)) bus();

    alu_muldiv_iter #(.DataWidth(W), .TagWidth(5)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [127:0] pa, pb, p;
        int sa, sbv;
        sa  = a;
        sbv = b;
        if (!op[2]) begin
            pa = (op == 3'b001 || op == 3'b010) ? 128'(sa) : $signed({96'b0, a});
            pb = (op == 3'b001) ? 128'(sbv) : $signed({96'b0, b});
            p  = pa * pb;
            return (op == 3'b000) ? p[31:0] : p[63:32];
        end
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
        case (op[1:0])
            2'b00:   return 32'(sa / sbv);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sbv);
            default: return a % b;
        endcase
    endfunction

    function automatic int unsigned exp_lat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_RADIX4_EN
        if (!op[2]) return W/2 + 2;
`endif
        return W + 2;
    endfunction

    task automatic drive_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [4:0] tg, input bit track);
        int unsigned guard = 0;
        @(negedge clk);
        while (!bus.ready_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", bus.ready_o, 1'b1);
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.srcA_i  = a;
        bus.srcB_i  = b;
        bus.tag_i   = tg;
        @(posedge clk);
        #1;
        if (track) sb.push_back('{res: model(op, a, b), tag: tg, acc_cyc: cyc, lat: exp_lat(op, a, b)});
        bus.valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("drain", sb.size(), 0);
    endtask

    // Each result is compared on the first cycle its valid_o is seen.
    always @(negedge clk) begin
        if (rst_n && bus.valid_o && !prev_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", bus.valid_o, 1'b0);
            end else begin
                e = sb.pop_front();
                check("result", bus.result_o, e.res);
                check("tag", bus.tag_o, e.tag);
                check("latency", cyc - e.acc_cyc + 1, e.lat);
                check("zero", bus.zero_o, e.res == 0);
                check("negative", bus.negative_o, e.res[W-1]);
            end
        end
        prev_valid = bus.valid_o;
    end

    logic [2:0]   d_op[13] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111,
                               3'b100, 3'b111, 3'b100, 3'b110, 3'b000};
    logic [W-1:0] d_a[13]  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                               32'hFFFF_FFF9, 32'd100, 32'd100, 32'd1234, 32'd5, 32'h8000_0000,
                               32'h8000_0000, 32'd0};
    logic [W-1:0] d_b[13]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                               32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'h1234_5678};

    initial begin
        logic [2:0]   rop;
        logic [W-1:0] ra, rb, hold_exp;
        int unsigned  guard;

        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.op_i    = '0;
        bus.srcA_i  = '0;
        bus.srcB_i  = '0;
        bus.tag_i   = '0;
        bus.ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.valid_o, 1'b0);
        check("rst_ready", bus.ready_o, 1'b1);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_result", bus.result_o, 0);
        check("rst_tag", bus.tag_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive_op(d_op[i], d_a[i], d_b[i], 5'(i + 1), 1'b1);
            wait_drain();
        end

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : $urandom;
            drive_op(rop, ra, rb, 5'(20 + i), 1'b1);
            wait_drain();
        end

        // Consumer stalls for ten cycles while the result must stay put.
        bus.ready_i = 1'b0;
        hold_exp = model(3'b011, 32'hDEAD_BEEF, 32'h0000_1000);
        drive_op(3'b011, 32'hDEAD_BEEF, 32'h0000_1000, 5'd17, 1'b1);
        guard = 0;
        while (!bus.valid_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", bus.valid_o, 1'b1);
            check("hold_result", bus.result_o, hold_exp);
            check("hold_tag", bus.tag_o, 17);
            check("hold_ready", bus.ready_o, 1'b0);
        end
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", bus.valid_o, 1'b0);
        check("release_ready", bus.ready_o, 1'b1);
        wait_drain();
        drive_op(3'b101, 32'd100, 32'd7, 5'd9, 1'b1);
        wait_drain();

        // Abort during CALC: nothing may come out.
        drive_op(3'b000, 32'd7, 32'd9, 5'd11, 1'b0);
        repeat (5) @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        check("flush_ready", bus.ready_o, 1'b1);
        check("flush_busy", bus.busy_o, 1'b0);
        check("flush_valid", bus.valid_o, 1'b0);
        repeat (40) @(negedge clk);
        check("flush_quiet", bus.valid_o, 1'b0);

        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.op_i    = 3'b100;
        bus.srcB_i  = 32'd0;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        check("flush_accept_busy", bus.busy_o, 1'b0);
        check("flush_accept_valid", bus.valid_o, 1'b0);

        // Asynchronous reset in the middle of a calculation.
        drive_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("amid_rst_valid", bus.valid_o, 1'b0);
        check("amid_rst_ready", bus.ready_o, 1'b1);
        check("amid_rst_busy", bus.busy_o, 1'b0);
        check("amid_rst_result", bus.result_o, 0);
        check("amid_rst_tag", bus.tag_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive_op(3'b110, 32'hFFFF_FF9C, 32'd7, 5'd30, 1'b1);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d expected 0", 1);
        $fatal(1, "timeout");
    end
endmodule
